// File: rtl/mem_port_arbiter_pkg.sv
// Shared arbiter types and constants for the core memory port.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } arb_owner_t;

  localparam logic [3:0]  MEM_MASK_WORD = 4'hF;
  localparam int unsigned WAIT_CNT_W    = 8;
  localparam int unsigned DSTREAK_W     = 4;

endpackage

// File: rtl/arb_watchdog.sv
// Wait-state counter with timeout compare for one memory access.
module arb_watchdog
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic start,
  input  logic busy,
  input  logic ready,
  output logic timeout
);

  localparam logic [WAIT_CNT_W-1:0] LIMIT =
    (TIMEOUT == 0) ? '0 : WAIT_CNT_W'(TIMEOUT - 1);

  logic [WAIT_CNT_W-1:0] wait_cnt;

  // Count busy cycles without ready; restart on every grant.
  always_ff @(posedge clk_in) begin
    if (rst_in || start) begin
      wait_cnt <= '0;
    end else if (busy && !ready && (wait_cnt != '1)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Abort request when the limit is reached and ready is still low.
  always_comb begin
    timeout = (TIMEOUT != 0) && busy && !ready && (wait_cnt == LIMIT);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch / load-store arbiter for a single-port external memory.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = 4,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        i_req_in,
  input  logic [31:0] i_addr_in,
  output logic        i_gnt_out,
  output logic        i_ack_out,
  output logic [31:0] i_rdata_out,
  output logic        i_err_out,
  input  logic        d_req_in,
  input  logic        d_wr_in,
  input  logic [31:0] d_addr_in,
  input  logic [31:0] d_wdata_in,
  input  logic [3:0]  d_mask_in,
  output logic        d_gnt_out,
  output logic        d_ack_out,
  output logic [31:0] d_rdata_out,
  output logic        d_err_out,
  output logic        mem_req_out,
  output logic        mem_wr_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wdata_out,
  output logic [3:0]  mem_mask_out,
  input  logic [31:0] mem_rdata_in,
  input  logic        mem_ready_in
);

  localparam logic [DSTREAK_W-1:0] STREAK_MAX = DSTREAK_W'(MAX_DSTREAK);

  arb_state_t           state;
  arb_owner_t           owner;
  logic [DSTREAK_W-1:0] dstreak;
  logic                 grant_i;
  logic                 grant_d;
  logic                 busy;
  logic                 timeout;

  // Grant selection in IDLE: data first unless the fetch has waited long enough.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if ((state == ARB_IDLE) && !rst_in) begin
      if (d_req_in && !(i_req_in && (dstreak == STREAK_MAX))) begin
        grant_d = 1'b1;
      end else if (i_req_in) begin
        grant_i = 1'b1;
      end
    end
  end

  // Decode owner and drive the grant pulses.
  always_comb begin
    busy      = (state != ARB_IDLE);
    owner     = (state == ARB_BUSY_D) ? OWNER_D : OWNER_I;
    i_gnt_out = grant_i;
    d_gnt_out = grant_d;
  end

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .start   (grant_i || grant_d),
    .busy    (busy),
    .ready   (mem_ready_in),
    .timeout (timeout)
  );

  // Arbiter FSM with registered bus and response outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= ARB_IDLE;
      dstreak       <= '0;
      mem_req_out   <= 1'b0;
      mem_wr_out    <= 1'b0;
      mem_addr_out  <= '0;
      mem_wdata_out <= '0;
      mem_mask_out  <= '0;
      i_ack_out     <= 1'b0;
      i_err_out     <= 1'b0;
      i_rdata_out   <= '0;
      d_ack_out     <= 1'b0;
      d_err_out     <= 1'b0;
      d_rdata_out   <= '0;
    end else begin
      i_ack_out <= 1'b0;
      i_err_out <= 1'b0;
      d_ack_out <= 1'b0;
      d_err_out <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_d) begin
            state         <= ARB_BUSY_D;
            mem_req_out   <= 1'b1;
            mem_wr_out    <= d_wr_in;
            mem_addr_out  <= d_addr_in;
            mem_wdata_out <= d_wr_in ? d_wdata_in : '0;
            mem_mask_out  <= d_wr_in ? d_mask_in : MEM_MASK_WORD;
            if (i_req_in) begin
              if (dstreak != STREAK_MAX) begin
                dstreak <= dstreak + 1'b1;
              end
            end else begin
              dstreak <= '0;
            end
          end else if (grant_i) begin
            state         <= ARB_BUSY_I;
            mem_req_out   <= 1'b1;
            mem_wr_out    <= 1'b0;
            mem_addr_out  <= i_addr_in;
            mem_wdata_out <= '0;
            mem_mask_out  <= MEM_MASK_WORD;
            dstreak       <= '0;
          end
        end
        ARB_BUSY_I, ARB_BUSY_D: begin
          if (mem_ready_in) begin
            state       <= ARB_IDLE;
            mem_req_out <= 1'b0;
            if (owner == OWNER_D) begin
              d_ack_out   <= 1'b1;
              d_rdata_out <= mem_wr_out ? '0 : mem_rdata_in;
            end else begin
              i_ack_out   <= 1'b1;
              i_rdata_out <= mem_rdata_in;
            end
          end else if (timeout) begin
            state       <= ARB_IDLE;
            mem_req_out <= 1'b0;
            if (owner == OWNER_D) begin
              d_ack_out   <= 1'b1;
              d_err_out   <= 1'b1;
              d_rdata_out <= '0;
            end else begin
              i_ack_out   <= 1'b1;
              i_err_out   <= 1'b1;
              i_rdata_out <= '0;
            end
          end
        end
        default: begin
          state       <= ARB_IDLE;
          mem_req_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  localparam int TB_MAX     = 4;
  localparam int TB_TIMEOUT = 16;

  logic        clk;
  logic        rst_in;
  logic        i_req_in;
  logic [31:0] i_addr_in;
  logic        i_gnt_out, i_ack_out, i_err_out;
  logic [31:0] i_rdata_out;
  logic        d_req_in, d_wr_in;
  logic [31:0] d_addr_in, d_wdata_in;
  logic [3:0]  d_mask_in;
  logic        d_gnt_out, d_ack_out, d_err_out;
  logic [31:0] d_rdata_out;
  logic        mem_req_out, mem_wr_out;
  logic [31:0] mem_addr_out, mem_wdata_out;
  logic [3:0]  mem_mask_out;
  logic [31:0] mem_rdata_in;
  logic        mem_ready_in;

  // second instance with the watchdog disabled
  logic        nt_i_req;
  logic [31:0] nt_i_addr;
  logic        nt_i_gnt, nt_i_ack, nt_i_err;
  logic [31:0] nt_i_rdata;
  logic        nt_d_gnt, nt_d_ack, nt_d_err;
  logic [31:0] nt_d_rdata;
  logic        nt_mem_req, nt_mem_wr;
  logic [31:0] nt_mem_addr, nt_mem_wdata;
  logic [3:0]  nt_mem_mask;
  logic [31:0] nt_rdata;
  logic        nt_ready;

  int checks = 0;
  int errors = 0;

  int          mem_wait = 0;
  logic [31:0] mem_data = 32'h0;
  int          rcnt     = 0;

  mem_port_arbiter #(.MAX_DSTREAK(TB_MAX), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk_in(clk), .rst_in(rst_in),
    .i_req_in(i_req_in), .i_addr_in(i_addr_in), .i_gnt_out(i_gnt_out),
    .i_ack_out(i_ack_out), .i_rdata_out(i_rdata_out), .i_err_out(i_err_out),
    .d_req_in(d_req_in), .d_wr_in(d_wr_in), .d_addr_in(d_addr_in),
    .d_wdata_in(d_wdata_in), .d_mask_in(d_mask_in), .d_gnt_out(d_gnt_out),
    .d_ack_out(d_ack_out), .d_rdata_out(d_rdata_out), .d_err_out(d_err_out),
    .mem_req_out(mem_req_out), .mem_wr_out(mem_wr_out), .mem_addr_out(mem_addr_out),
    .mem_wdata_out(mem_wdata_out), .mem_mask_out(mem_mask_out),
    .mem_rdata_in(mem_rdata_in), .mem_ready_in(mem_ready_in)
  );

  mem_port_arbiter #(.MAX_DSTREAK(TB_MAX), .TIMEOUT(0)) dut_nt (
    .clk_in(clk), .rst_in(rst_in),
    .i_req_in(nt_i_req), .i_addr_in(nt_i_addr), .i_gnt_out(nt_i_gnt),
    .i_ack_out(nt_i_ack), .i_rdata_out(nt_i_rdata), .i_err_out(nt_i_err),
    .d_req_in(1'b0), .d_wr_in(1'b0), .d_addr_in(32'h0),
    .d_wdata_in(32'h0), .d_mask_in(4'h0), .d_gnt_out(nt_d_gnt),
    .d_ack_out(nt_d_ack), .d_rdata_out(nt_d_rdata), .d_err_out(nt_d_err),
    .mem_req_out(nt_mem_req), .mem_wr_out(nt_mem_wr), .mem_addr_out(nt_mem_addr),
    .mem_wdata_out(nt_mem_wdata), .mem_mask_out(nt_mem_mask),
    .mem_rdata_in(nt_rdata), .mem_ready_in(nt_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: ready after mem_wait wait states, junk data otherwise.
  initial begin
    mem_ready_in = 1'b0;
    mem_rdata_in = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req_out === 1'b1) rcnt++;
      else rcnt = 0;
      mem_ready_in = (mem_req_out === 1'b1) && (rcnt > mem_wait);
      mem_rdata_in = mem_ready_in ? mem_data : (32'hBAD0_0000 ^ 32'(rcnt));
    end
  end

  // ---------------- behavioural model ----------------
  bit          m_valid = 0, m_zero = 0, m_busy = 0, m_own_d = 0, m_wr = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;
  logic [3:0]  m_mask = 0;
  int          m_low = 0, m_streak = 0;
  bit          e_iack = 0, e_dack = 0, e_ierr = 0, e_derr = 0;
  logic [31:0] e_rdata = 0;

  // 0 = nobody, 1 = fetch, 2 = data
  function automatic int pick(bit ireq, bit dreq, int streak);
    if (dreq && !(ireq && streak >= TB_MAX)) return 2;
    if (ireq) return 1;
    return 0;
  endfunction

  task automatic compare_outputs();
    int g;
    g = (m_busy || rst_in) ? 0 : pick(i_req_in, d_req_in, m_streak);
    chk("i_gnt", {31'b0, i_gnt_out}, {31'b0, g == 1});
    chk("d_gnt", {31'b0, d_gnt_out}, {31'b0, g == 2});
    chk("mem_req", {31'b0, mem_req_out}, {31'b0, m_busy});
    if (m_busy) begin
      chk("mem_addr", mem_addr_out, m_addr);
      chk("mem_wr", {31'b0, mem_wr_out}, {31'b0, m_wr});
      chk("mem_mask", {28'b0, mem_mask_out}, {28'b0, m_mask});
      if (m_wr) chk("mem_wdata", mem_wdata_out, m_wdata);
    end
    chk("i_ack", {31'b0, i_ack_out}, {31'b0, e_iack});
    chk("d_ack", {31'b0, d_ack_out}, {31'b0, e_dack});
    chk("i_err", {31'b0, i_err_out}, {31'b0, e_ierr});
    chk("d_err", {31'b0, d_err_out}, {31'b0, e_derr});
    if (e_iack) chk("i_rdata", i_rdata_out, e_rdata);
    if (e_dack) chk("d_rdata", d_rdata_out, e_rdata);
    if (m_zero) begin
      chk("rst_mem_addr", mem_addr_out, 32'h0);
      chk("rst_mem_wdata", mem_wdata_out, 32'h0);
      chk("rst_mem_mask", {28'b0, mem_mask_out}, 32'h0);
      chk("rst_mem_wr", {31'b0, mem_wr_out}, 32'h0);
      chk("rst_i_rdata", i_rdata_out, 32'h0);
      chk("rst_d_rdata", d_rdata_out, 32'h0);
    end
  endtask

  task automatic advance_model();
    int g;
    if (rst_in) begin
      m_valid = 1; m_zero = 1; m_busy = 0; m_streak = 0; m_low = 0;
      e_iack = 0; e_dack = 0; e_ierr = 0; e_derr = 0; e_rdata = 0;
    end else if (m_valid) begin
      m_zero = 0;
      e_iack = 0; e_dack = 0; e_ierr = 0; e_derr = 0;
      if (!m_busy) begin
        g = pick(i_req_in, d_req_in, m_streak);
        if (g == 2) begin
          m_busy = 1; m_own_d = 1; m_wr = d_wr_in; m_addr = d_addr_in;
          m_wdata = d_wdata_in; m_mask = d_wr_in ? d_mask_in : 4'hF; m_low = 0;
          m_streak = i_req_in ? ((m_streak + 1 > TB_MAX) ? TB_MAX : m_streak + 1) : 0;
        end else if (g == 1) begin
          m_busy = 1; m_own_d = 0; m_wr = 0; m_addr = i_addr_in;
          m_mask = 4'hF; m_low = 0; m_streak = 0;
        end
      end else if (mem_ready_in) begin
        m_busy = 0;
        if (m_own_d) e_dack = 1; else e_iack = 1;
        e_rdata = (m_own_d && m_wr) ? 32'h0 : mem_rdata_in;
      end else begin
        m_low++;
        if (TB_TIMEOUT != 0 && m_low == TB_TIMEOUT) begin
          m_busy = 0;
          if (m_own_d) begin e_dack = 1; e_derr = 1; end
          else begin e_iack = 1; e_ierr = 1; end
          e_rdata = 32'h0;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) compare_outputs();
      advance_model();
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int          cnt, seen, gcount, acks;
    logic        err;
    logic [31:0] rd;
    logic [9:0]  seq;

    rst_in = 1; i_req_in = 0; i_addr_in = 0; d_req_in = 0; d_wr_in = 0;
    d_addr_in = 0; d_wdata_in = 0; d_mask_in = 0;
    nt_i_req = 0; nt_i_addr = 0; nt_rdata = 0; nt_ready = 0;
    step(); step();
    rst_in = 0;
    @(negedge clk);
    chk("reset_mem_req", {31'b0, mem_req_out}, 32'h0);
    chk("reset_i_ack", {31'b0, i_ack_out}, 32'h0);
    chk("reset_mem_addr", mem_addr_out, 32'h0);

    // 1: zero-wait fetch
    step();
    mem_wait = 0; mem_data = 32'h0000_0013; i_addr_in = 32'h100; i_req_in = 1;
    @(negedge clk);
    chk("t1_i_gnt", {31'b0, i_gnt_out}, 32'h1);
    step(); i_req_in = 0;
    @(negedge clk);
    chk("t1_mem_req", {31'b0, mem_req_out}, 32'h1);
    chk("t1_mem_addr", mem_addr_out, 32'h100);
    chk("t1_mem_mask", {28'b0, mem_mask_out}, 32'hF);
    step();
    @(negedge clk);
    chk("t1_i_ack", {31'b0, i_ack_out}, 32'h1);
    chk("t1_i_rdata", i_rdata_out, 32'h13);
    chk("t1_i_err", {31'b0, i_err_out}, 32'h0);

    // 2: simultaneous requests, store wins
    step();
    mem_data = 32'h5555_5555; i_req_in = 1; i_addr_in = 32'h300;
    d_req_in = 1; d_wr_in = 1; d_addr_in = 32'h2004; d_wdata_in = 32'hDEAD_BEEF; d_mask_in = 4'b0011;
    @(negedge clk);
    chk("t2_d_gnt", {31'b0, d_gnt_out}, 32'h1);
    chk("t2_i_gnt_held", {31'b0, i_gnt_out}, 32'h0);
    step(); d_req_in = 0;
    @(negedge clk);
    chk("t2_mem_wr", {31'b0, mem_wr_out}, 32'h1);
    chk("t2_mem_mask", {28'b0, mem_mask_out}, 32'h3);
    chk("t2_mem_addr", mem_addr_out, 32'h2004);
    chk("t2_mem_wdata", mem_wdata_out, 32'hDEAD_BEEF);
    step();
    @(negedge clk);
    chk("t2_d_ack", {31'b0, d_ack_out}, 32'h1);
    chk("t2_d_rdata", d_rdata_out, 32'h0);
    chk("t2_i_gnt", {31'b0, i_gnt_out}, 32'h1);
    step(); i_req_in = 0;
    step();
    @(negedge clk);
    chk("t2_i_rdata", i_rdata_out, 32'h5555_5555);

    // 3: anti-starvation pattern
    step();
    mem_data = 32'h1234_5678; d_wr_in = 0; d_addr_in = 32'h400; i_addr_in = 32'h500;
    i_req_in = 1; d_req_in = 1;
    gcount = 0; seq = '0;
    for (int c = 0; c < 60 && gcount < 10; c++) begin
      @(negedge clk);
      if (d_gnt_out) gcount++;
      else if (i_gnt_out) begin seq[gcount] = 1'b1; gcount++; end
      step();
    end
    i_req_in = 0; d_req_in = 0;
    chk("t3_grants", 32'(gcount), 32'd10);
    chk("t3_pattern", {22'b0, seq}, 32'h210);
    step(); step(); step();

    // 4: watchdog timeout on a fetch
    mem_wait = 1000; mem_data = 32'h7777_0000; i_addr_in = 32'h600; i_req_in = 1;
    step(); i_req_in = 0;
    cnt = 0; seen = 0; err = 0; rd = 32'hFFFF_FFFF;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_req_out) cnt++;
      if (i_ack_out) begin seen = 1; err = i_err_out; rd = i_rdata_out; break; end
      step();
    end
    chk("t4_req_cycles", 32'(cnt), 32'd16);
    chk("t4_ack_seen", 32'(seen), 32'd1);
    chk("t4_err", {31'b0, err}, 32'h1);
    chk("t4_rdata", rd, 32'h0);

    // 5: ready coincides with the timeout limit
    step();
    mem_wait = 15; mem_data = 32'hA5A5_0F0F; d_wr_in = 0; d_addr_in = 32'h700; d_req_in = 1;
    step(); d_req_in = 0;
    cnt = 0; seen = 0; err = 1; rd = 32'h0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_req_out) cnt++;
      if (d_ack_out) begin seen = 1; err = d_err_out; rd = d_rdata_out; break; end
      step();
    end
    chk("t5_req_cycles", 32'(cnt), 32'd16);
    chk("t5_ack_seen", 32'(seen), 32'd1);
    chk("t5_err", {31'b0, err}, 32'h0);
    chk("t5_rdata", rd, 32'hA5A5_0F0F);

    // 6: reset in the middle of a data access
    step();
    mem_wait = 1000; d_addr_in = 32'h800; d_req_in = 1;
    step(); d_req_in = 0;
    step(); step();
    step(); rst_in = 1;
    step(); rst_in = 0;
    @(negedge clk);
    chk("t6_mem_req", {31'b0, mem_req_out}, 32'h0);
    chk("t6_d_ack", {31'b0, d_ack_out}, 32'h0);
    chk("t6_mem_addr", mem_addr_out, 32'h0);
    acks = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      @(negedge clk);
      if (i_ack_out || d_ack_out) acks++;
    end
    chk("t6_no_ack", 32'(acks), 32'd0);
    step();
    mem_wait = 2; mem_data = 32'h0BAD_F00D; d_addr_in = 32'h900; d_req_in = 1;
    @(negedge clk);
    chk("t6_regrant", {31'b0, d_gnt_out}, 32'h1);
    step(); d_req_in = 0;
    seen = 0; rd = 32'h0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (d_ack_out) begin seen = 1; rd = d_rdata_out; break; end
      step();
    end
    chk("t6_ack_seen", 32'(seen), 32'd1);
    chk("t6_rdata", rd, 32'h0BAD_F00D);

    // 4b: watchdog disabled waits indefinitely
    step();
    nt_i_addr = 32'hA00; nt_i_req = 1;
    @(negedge clk);
    chk("nt_i_gnt", {31'b0, nt_i_gnt}, 32'h1);
    step(); nt_i_req = 0;
    cnt = 0; acks = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (nt_mem_req) cnt++;
      if (nt_i_ack) acks++;
      step();
    end
    chk("nt_req_cycles", 32'(cnt), 32'd60);
    chk("nt_no_ack", 32'(acks), 32'd0);
    chk("nt_mem_addr", nt_mem_addr, 32'hA00);
    chk("nt_mem_mask", {28'b0, nt_mem_mask}, 32'hF);
    chk("nt_mem_wr", {31'b0, nt_mem_wr}, 32'h0);
    nt_ready = 1; nt_rdata = 32'hCAFE_F00D;
    step(); nt_ready = 0;
    @(negedge clk);
    chk("nt_i_ack", {31'b0, nt_i_ack}, 32'h1);
    chk("nt_i_err", {31'b0, nt_i_err}, 32'h0);
    chk("nt_i_rdata", nt_i_rdata, 32'hCAFE_F00D);
    chk("nt_mem_req_drop", {31'b0, nt_mem_req}, 32'h0);
    chk("nt_d_side", {29'b0, nt_d_gnt, nt_d_ack, nt_d_err}, 32'h0);
    chk("nt_d_rdata", nt_d_rdata, 32'h0);
    chk("nt_mem_wdata", nt_mem_wdata, 32'h0);

    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
